mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one single-port data/instruction memory among three requesters: 0 = instruction fetch, 1 = CU load/store, 2 = DMA/debug.
- Sits between the control-unit-driven datapath and the memory.
- Performs round-robin arbitration, a req/gnt/done handshake and a programmable wait-state sequence per access.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- WAIT_CYCLES, 1, extra memory cycles per access (0 legal); mem_en is high for WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  3  per-requester request; held until done.
- we  in  3  per-requester write enable; 1 = write.
- addr  in  3*AW  requester i occupies bits [i*AW +: AW].
- wdata  in  3*DW  requester i occupies bits [i*DW +: DW].
- gnt  out  3  one-hot grant; high for the whole ACCESS state.
- done  out  3  one-cycle completion pulse to the served requester.
- rdata  out  DW  read data; valid while done is high and held until the next done.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid on the final ACCESS cycle.

Behaviour:
- Reset (asynchronous, also mid-transaction):
  - state=IDLE, all outputs 0, last=2 (so requester 0 wins first), cnt=0.
  - Any transaction in flight is abandoned; no done pulse is issued for it.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If req!=0, pick the winner in round-robin order last+1, last+2, last+3 (mod 3).
  - At the edge: gnt<=onehot(winner), last<=winner, mem_addr/mem_we/mem_wdata<=the winner's fields, cnt<=WAIT_CYCLES, go to ACCESS.
  - If req==0, stay in IDLE with all outputs 0.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata stay stable from the registered copy, so requester input changes are ignored.
  - Each edge: if cnt==0, rdata<=mem_rdata (reads only; rdata is unchanged on writes), done[winner]<=1, gnt<=0, mem_en/mem_we<=0, go to DONE. Otherwise cnt<=cnt-1.
- DONE: done stays high exactly one cycle; the next edge clears done and returns to IDLE. No arbitration happens in DONE.
- Latency:
  - With req sampled at edge E0, gnt and mem_en are high from E0 through E0+WAIT_CYCLES+1.
  - done is high in the cycle after that; the next arbitration is at edge E0+WAIT_CYCLES+3.
  - Throughput is one access per WAIT_CYCLES+3 cycles.
- Requester rules:
  - req must drop by the edge following done, or the requester is re-considered at its round-robin turn.
  - Dropping req during ACCESS does not abort the access; done still pulses.
- Invariants: gnt is zero or one-hot; done is zero or one-hot; done[i] implies gnt[i] was high on the previous cycle.
- Width: cnt is max(1, $clog2(WAIT_CYCLES+1)) bits; no arithmetic beyond the decrement.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority 0 > 1 > 2; last is still updated but ignored; requester 0 can starve the others.
- Undefined: round-robin as specified above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - NREQ=3;
  - index constants REQ_IFETCH=0, REQ_CU=1, REQ_DMA=2.
- One sub-module, rr_picker: combinational; inputs req[2:0] and last[1:0]; outputs winner[1:0] and valid.
  - It contains the ARB_FIXED_PRIORITY_EN branch.

Test Plan:
- Read, WAIT_CYCLES=1: req[0]=1, addr0=0x10, mem returns 0xA5.
  -> gnt=001 and mem_en=1 for 2 cycles with mem_addr=0x10, mem_we=0; then done=001 and rdata=0xA5 for 1 cycle.
- Fairness: req=111 held continuously.
  -> grant sequence 001, 010, 100, 001; each access period is 4 cycles (WAIT_CYCLES=1).
- Write: req[1], we[1]=1, addr1=0x20, wdata1=0x3C.
  -> mem_we=1, mem_addr=0x20, mem_wdata=0x3C throughout ACCESS; done=010; rdata unchanged.
- Abort attempt: req[2] drops and addr2 changes during ACCESS.
  -> mem_addr stays at the original value; done=100 still pulses.
- Reset mid-access: rst pulse in the second ACCESS cycle.
  -> all outputs 0 immediately, no done pulse; with req=111 afterwards, the first grant is 001.
- ARB_FIXED_PRIORITY_EN defined: req=110 held.
  -> gnt=010 every transaction until req[1] drops, then 100.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   state_t    : arbiter FSM states
//   NREQ       : number of requesters
//   REQ_*      : requester index constants
package mem_arb_pkg;

  localparam int NREQ = 3;

  localparam int REQ_IFETCH = 0;
  localparam int REQ_CU     = 1;
  localparam int REQ_DMA    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester/memory bus bundle for mem_bus_arbiter.
//   req/we/addr/wdata : per-requester request fields (requester i in slice i)
//   gnt/done/rdata    : per-requester grant, completion pulse, shared read data
//   mem_*             : single-port memory side
// slave  : arbiter view
// master : requesters + memory view
interface mem_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  import mem_arb_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// rr_picker: combinational winner selection among NREQ requesters.
//   req_i    : request vector
//   last_i   : index of the previously served requester
//   winner_o : selected requester index
//   valid_o  : any request present
// Macro ARB_FIXED_PRIORITY_EN: fixed priority 0 > 1 > 2 (last_i ignored);
// otherwise round-robin starting after last_i.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_i,
  output logic [1:0]      winner_o,
  output logic            valid_o
);

  assign valid_o = |req_i;

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    winner_o = 2'd0;
    // Walk lowest priority first so the highest-priority request overrides.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) winner_o = 2'(k);
    end
  end
`else
  always_comb begin
    winner_o = 2'd0;
    // Visit last+3 .. last+1 so the nearest candidate after last wins.
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % NREQ]) winner_o = 2'((int'(last_i) + k) % NREQ);
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory among three requesters
// (0 = ifetch, 1 = CU load/store, 2 = DMA/debug) with a req/gnt/done
// handshake and WAIT_CYCLES extra memory cycles per access.
//   clk, rst : clock (rising), async active-high reset
//   bus      : mem_bus_arbiter_if.slave (requester fields, grants, memory side)
// Macro ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      win_q, win_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic [1:0]      pick_win;
  logic            pick_vld;

  rr_picker u_pick (
    .req_i    (bus.req),
    .last_i   (last_q),
    .winner_o (pick_win),
    .valid_o  (pick_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 2'(REQ_DMA);  // requester 0 wins the first arbitration
      win_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          // Latch the winner's request so later input changes are ignored.
          gnt_d           = '0;
          gnt_d[pick_win] = 1'b1;
          last_d          = pick_win;
          win_d           = pick_win;
          mem_en_d        = 1'b1;
          mem_we_d        = bus.we[pick_win];
          mem_addr_d      = bus.addr[int'(pick_win)*AW +: AW];
          mem_wdata_d     = bus.wdata[int'(pick_win)*DW +: DW];
          cnt_d           = CW'(WAIT_CYCLES);
          state_d         = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!mem_we_q) rdata_d = bus.mem_rdata;
          done_d        = '0;
          done_d[win_q] = 1'b1;
          gnt_d         = '0;
          mem_en_d      = 1'b0;
          mem_we_d      = 1'b0;
          mem_addr_d    = '0;
          mem_wdata_d   = '0;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        done_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
